// File: rtl/input_conditioner.sv
// Per-bit synchroniser + debouncer with registered rise/fall pulses and an aggregate change strobe.
// Define COND_EDGE_LATCH_EN to add sticky per-bit edge flags (clr_edges / edge_latched).
module input_conditioner #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
`ifdef COND_EDGE_LATCH_EN
  input  logic             clr_edges,
  output logic [WIDTH-1:0] edge_latched,
`endif
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // A run of differing samples must reach the terminal count unbroken;
  // any sample matching clean restarts it, which is what rejects glitches.
  always_comb begin
    clean_d = clean;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != clean[i]) begin
        if (cnt_q[i] == TERM) begin
          clean_d[i] = sync[i];
          rise_d[i]  = sync[i];
          fall_d[i]  = clean[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      clean      <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      sync_q[0] <= raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      clean      <= clean_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= |(rise_d | fall_d);
    end
  end

`ifdef COND_EDGE_LATCH_EN
  // Sets from the registered pulses, so a pulse visible in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_latched <= '0;
    end else begin
      edge_latched <= (clr_edges ? '0 : edge_latched) | rise | fall;
    end
  end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scoreboard bench for input_conditioner; expected outputs are pushed per driven cycle
// and popped once the DUT has taken the corresponding clock edge.
module tb_input_conditioner;
  localparam int W   = 10;
  localparam int LAT = 6;

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] lat;
    logic         any;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] raw_in;
  logic [W-1:0] clean;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;
`ifdef COND_EDGE_LATCH_EN
  logic         clr_edges;
  logic [W-1:0] edge_latched;
  logic [W-1:0] prev_pulse;
`endif

  exp_t         exp_q[$];
  logic [W-1:0] e_clean;
  logic [W-1:0] e_lat;
  int           n_vec;
  int           n_err;

  input_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
`ifdef COND_EDGE_LATCH_EN
    .clr_edges    (clr_edges),
    .edge_latched (edge_latched),
`endif
    .clean        (clean),
    .rise         (rise),
    .fall         (fall),
    .any_change   (any_change)
  );

  // clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, push the expectation for the coming edge, then pop and compare.
  task automatic cyc(input logic [W-1:0] r, input logic rs, input logic c,
                     input logic [W-1:0] re, input logic [W-1:0] fe);
    exp_t e;
    exp_t g;
    raw_in = r;
    reset  = rs;
    if (rs) begin
      re = '0;
      fe = '0;
    end
    e_clean = rs ? '0 : ((e_clean | re) & ~fe);
`ifdef COND_EDGE_LATCH_EN
    clr_edges  = c;
    e_lat      = rs ? '0 : ((c ? '0 : e_lat) | prev_pulse);
    prev_pulse = re | fe;
`else
    e_lat = '0;
    if (c) e_lat = '0;
`endif
    e.clean = e_clean;
    e.rise  = re;
    e.fall  = fe;
    e.lat   = e_lat;
    e.any   = |(re | fe);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check_val("clean", 32'(clean), 32'(g.clean));
    check_val("rise", 32'(rise), 32'(g.rise));
    check_val("fall", 32'(fall), 32'(g.fall));
    check_val("any_change", 32'(any_change), 32'(g.any));
`ifdef COND_EDGE_LATCH_EN
    check_val("edge_latched", 32'(edge_latched), 32'(g.lat));
`endif
  endtask

  // Apply a stable new level from a settled state; pulses land exactly LAT edges later.
  task automatic settle(input logic [W-1:0] r, input logic c_last);
    logic [W-1:0] re;
    logic [W-1:0] fe;
    re = r & ~e_clean;
    fe = ~r & e_clean;
    for (int k = 1; k < LAT; k++) cyc(r, 1'b0, 1'b0, '0, '0);
    cyc(r, 1'b0, c_last, re, fe);
  endtask

  task automatic idle(input logic [W-1:0] r, input int n);
    for (int k = 0; k < n; k++) cyc(r, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] r;
    n_vec   = 0;
    n_err   = 0;
    e_clean = '0;
    e_lat   = '0;
`ifdef COND_EDGE_LATCH_EN
    prev_pulse = '0;
`endif

    // 1: reset with all inputs high, then a legitimate rise after the full latency
    for (int k = 0; k < 3; k++) cyc(10'h3FF, 1'b1, 1'b0, '0, '0);
    settle(10'h3FF, 1'b0);
    idle(10'h3FF, 3);
    settle(10'h000, 1'b0);
    idle(10'h000, 2);

    // 2: three-cycle glitch on bit 0 is rejected
    for (int k = 1; k <= 10; k++) cyc((k <= 3) ? 10'h001 : 10'h000, 1'b0, 1'b0, '0, '0);
    // four-cycle pulse on bit 1 is just long enough; fall follows at minimum spacing
    for (int k = 1; k <= 14; k++)
      cyc((k <= 4) ? 10'h002 : 10'h000, 1'b0, 1'b0,
          (k == 6) ? 10'h002 : 10'h000, (k == 10) ? 10'h002 : 10'h000);
    idle(10'h000, 2);

    // 3: bit 3 rise then fall
    settle(10'h008, 1'b0);
    idle(10'h008, 3);
    settle(10'h000, 1'b0);
    idle(10'h000, 2);

    // 4: bit 5 chatter every 2 cycles, then held high
    for (int k = 1; k <= 12; k++)
      cyc((((k - 1) / 2) % 2 == 0) ? 10'h020 : 10'h000, 1'b0, 1'b0, '0, '0);
    settle(10'h020, 1'b0);
    idle(10'h020, 2);
    settle(10'h000, 1'b0);
    idle(10'h000, 2);

    // 5: reset mid-count on bit 7 loses the run
    for (int k = 1; k <= 3; k++) cyc(10'h080, 1'b0, 1'b0, '0, '0);
    cyc(10'h080, 1'b1, 1'b0, '0, '0);
    settle(10'h080, 1'b0);
    idle(10'h080, 2);
    settle(10'h000, 1'b0);
    idle(10'h000, 2);

    // random simultaneous multi-bit changes
    for (int t = 0; t < 6; t++) begin
      r = W'($urandom_range(1, (1 << W) - 1));
      settle(r, 1'b0);
      idle(r, $urandom_range(0, 3));
    end
    settle(10'h000, 1'b0);
    idle(10'h000, 2);

`ifdef COND_EDGE_LATCH_EN
    // 6: sticky flags, clear coinciding with a new pulse
    settle(10'h004, 1'b0);
    idle(10'h004, 3);
    settle(10'h204, 1'b0);
    cyc(10'h204, 1'b0, 1'b1, '0, '0);
    idle(10'h204, 2);
    cyc(10'h204, 1'b0, 1'b1, '0, '0);
    idle(10'h204, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
